// File: rtl/hack_data_memory.sv
// Hack data-memory responder: 16K RAM, 8K-word screen buffer and keyboard register,
// plus a raster scanner that streams screen pixels LSB-first with no gaps between words.
module hack_data_memory #(
  parameter int ROW_WORDS = 32,   // power of two, >= 2
  parameter int ROWS      = 256   // power of two, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  input  logic        scan_en,
  output logic        pixel,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic        addr_err
);

  localparam int          RAM_DEPTH    = 16384;
  localparam int          SCREEN_WORDS = 8192;
  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;
  localparam int          COL_W        = $clog2(ROW_WORDS);
  localparam int          ROW_W        = $clog2(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} scan_state_t;

  logic [15:0]      r_ram    [RAM_DEPTH];
  logic [15:0]      r_screen [SCREEN_WORDS];
  logic [15:0]      r_kbd;
  logic             r_addr_err;

  scan_state_t      r_state;
  logic [3:0]       r_bit;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [15:0]      r_shift;
  logic             r_pixel;
  logic             r_pixel_valid;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_is_ram;
  logic             w_is_scr;
  logic             w_is_kbd;
  logic [3:0]       w_nxt_bit;
  logic [COL_W-1:0] w_nxt_col;
  logic [ROW_W-1:0] w_nxt_row;
  logic             w_wrap;
  logic             w_nxt_line;
  logic [12:0]      w_fetch_idx;
  logic [15:0]      w_fetch_word;

  assign w_is_ram = (addressM < SCREEN_BASE);
  assign w_is_scr = (addressM >= SCREEN_BASE) && (addressM < KBD_ADDR);
  assign w_is_kbd = (addressM == KBD_ADDR);

  // CPU read mux, combinational from the address
  always_comb begin
    inM = 16'h0000;
    if (w_is_ram) begin
      inM = r_ram[addressM[13:0]];
    end else if (w_is_scr) begin
      inM = r_screen[addressM[12:0]];
    end else if (w_is_kbd) begin
      inM = r_kbd;
    end else begin
      inM = 16'h0000;
    end
  end

  // Memory arrays survive reset; a same-edge scanner fetch sees the pre-write word
  always_ff @(posedge clk) begin
    if (writeM && w_is_ram) r_ram[addressM[13:0]] <= outM;
    if (writeM && w_is_scr) r_screen[addressM[12:0]] <= outM;
  end

  // Keyboard register and sticky illegal-write flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kbd      <= 16'h0000;
      r_addr_err <= 1'b0;
    end else begin
      if (kbd_valid && kbd_ready) r_kbd <= kbd_code;
      if (writeM && !w_is_ram && !w_is_scr) r_addr_err <= 1'b1;
    end
  end

  assign kbd_ready = ~reset;
  assign addr_err  = r_addr_err;

  // Counters wrap naturally because both dimensions are powers of two
  assign w_nxt_bit  = r_bit + 4'd1;
  assign w_nxt_col  = (&r_bit) ? r_col + 1'b1 : r_col;
  assign w_nxt_row  = ((&r_bit) && (&r_col)) ? r_row + 1'b1 : r_row;
  assign w_wrap     = (&r_bit) && (&r_col) && (&r_row);
  assign w_nxt_line = (w_nxt_bit == 4'd0) && (w_nxt_col == '0);
  // In LOAD the counters are all zero, so this also addresses word 0
  assign w_fetch_idx  = 13'({w_nxt_row, w_nxt_col});
  assign w_fetch_word = r_screen[w_fetch_idx];

  // Raster scanner FSM; outputs describe the pixel presented in the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bit         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_shift       <= 16'h0000;
      r_pixel       <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pixel       <= 1'b0;
          r_pixel_valid <= 1'b0;
          r_line_start  <= 1'b0;
          r_frame_start <= 1'b0;
          if (scan_en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift       <= w_fetch_word;
          r_pixel       <= w_fetch_word[0];
          r_pixel_valid <= 1'b1;
          r_line_start  <= 1'b1;
          r_frame_start <= 1'b1;
          r_state       <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_wrap && !scan_en) begin
            r_state       <= S_IDLE;
            r_bit         <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_pixel       <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
          end else begin
            r_bit <= w_nxt_bit;
            r_col <= w_nxt_col;
            r_row <= w_nxt_row;
            if (&r_bit) begin
              r_shift <= w_fetch_word;
              r_pixel <= w_fetch_word[0];
            end else begin
              r_shift <= r_shift >> 1;
              r_pixel <= r_shift[1];
            end
            r_pixel_valid <= 1'b1;
            r_line_start  <= w_nxt_line;
            r_frame_start <= w_nxt_line && (w_nxt_row == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixel       = r_pixel;
  assign pixel_valid = r_pixel_valid;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hack_data_memory.sv
// Bench for hack_data_memory: full-size instance for memory map and scan start,
// plus a tiny-frame instance (2x2 words) to exercise frame wrap and scan_en handling.
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] kbd_code;
  logic        kbd_valid;
  logic        scan_en_a, scan_en_b;
  logic [15:0] inM_a, inM_b;
  logic        kbd_ready_a, kbd_ready_b;
  logic        pixel_a, valid_a, line_a, frame_a, addr_err_a;
  logic        pixel_b, valid_b, line_b, frame_b, addr_err_b;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] kcode;
    logic        kval;
    logic        chk;
    logic [15:0] exp_inm;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [15:0] inm;
    logic        err;
  } exp_t;

  vec_t vecs [19];
  exp_t exp_q [$];

  hack_data_memory dut_a (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM_a), .kbd_code(kbd_code), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready_a),
    .scan_en(scan_en_a), .pixel(pixel_a), .pixel_valid(valid_a), .line_start(line_a),
    .frame_start(frame_a), .addr_err(addr_err_a)
  );

  hack_data_memory #(.ROW_WORDS(2), .ROWS(2)) dut_b (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM_b), .kbd_code(kbd_code), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready_b),
    .scan_en(scan_en_b), .pixel(pixel_b), .pixel_valid(valid_b), .line_start(line_b),
    .frame_start(frame_b), .addr_err(addr_err_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Full-size frame: word 0 = 0x0005, word 1 = 0x8000
  function automatic logic exp_px_a(input int k);
    logic [15:0] v;
    v = (k < 16) ? 16'h0005 : 16'h8000;
    return v[k % 16];
  endfunction

  // Tiny frame of 4 words; word 2 is rewritten during frame 1 and changes from frame 2 on
  function automatic logic exp_px_b(input int k);
    int w;
    logic [15:0] v;
    w = (k / 16) % 4;
    case (w)
      0:       v = 16'h0005;
      1:       v = 16'h8000;
      2:       v = (k >= 128) ? 16'h0F0F : 16'hFFFF;
      default: v = 16'h0000;
    endcase
    return v[k % 16];
  endfunction

  initial begin
    exp_t e;
    vecs[0]  = '{15'h0005, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{15'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0};
    vecs[2]  = '{15'h6001, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[3]  = '{15'h3FFF, 16'hABCD, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{15'h3FFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b0};
    vecs[5]  = '{15'h4000, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{15'h4000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b0};
    vecs[7]  = '{15'h4001, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{15'h4001, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0};
    vecs[9]  = '{15'h4002, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[10] = '{15'h4003, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{15'h5FFF, 16'h8001, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[12] = '{15'h5FFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h8001, 1'b0};
    vecs[13] = '{15'h6000, 16'h0000, 1'b0, 16'h0080, 1'b1, 1'b1, 16'h0000, 1'b0};
    vecs[14] = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0080, 1'b0};
    vecs[15] = '{15'h6000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0080, 1'b0};
    vecs[16] = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0080, 1'b1};
    vecs[17] = '{15'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[18] = '{15'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1};

    reset = 1'b1; addressM = 15'h0000; outM = 16'h0000; writeM = 1'b0;
    kbd_code = 16'h0000; kbd_valid = 1'b0; scan_en_a = 1'b0; scan_en_b = 1'b0;
    repeat (3) tick();
    chk("rst_pixel", pixel_a, 1'b0);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_line", line_a, 1'b0);
    chk("rst_frame", frame_a, 1'b0);
    chk("rst_addr_err", addr_err_a, 1'b0);
    chk("rst_kbd_ready", kbd_ready_a, 1'b0);
    reset = 1'b0;
    #1;
    chk("kbd_ready_run", kbd_ready_a, 1'b1);
    tick();

    // CPU port vectors; expectations travel through the scoreboard queue
    for (int i = 0; i < 19; i++) begin
      addressM  = vecs[i].addr;
      outM      = vecs[i].wdata;
      writeM    = vecs[i].wr;
      kbd_code  = vecs[i].kcode;
      kbd_valid = vecs[i].kval;
      exp_q.push_back('{vecs[i].chk, vecs[i].exp_inm, vecs[i].exp_err});
      #1;
      e = exp_q.pop_front();
      if (e.chk) chk($sformatf("vec%0d_inM", i), inM_a, e.inm);
      chk($sformatf("vec%0d_addr_err", i), addr_err_a, e.err);
      tick();
    end
    writeM = 1'b0; kbd_valid = 1'b0;
    chk("b_addr_err", addr_err_b, 1'b1);

    // Full-size scan: one LOAD cycle, then gapless pixels
    scan_en_a = 1'b1;
    tick();
    chk("a_load_gap", valid_a, 1'b0);
    tick();
    for (int k = 0; k <= 1000; k++) begin
      chk($sformatf("a_valid_%0d", k), valid_a, 1'b1);
      chk($sformatf("a_line_%0d", k), line_a, (k % 512) == 0);
      chk($sformatf("a_frame_%0d", k), frame_a, k == 0);
      if (k < 32) chk($sformatf("a_pixel_%0d", k), pixel_a, exp_px_a(k));
      if (k < 1000) tick();
    end

    // Mid-frame reset at pixel 1000
    reset = 1'b1;
    #1;
    chk("kbd_ready_in_reset", kbd_ready_a, 1'b0);
    tick();
    chk("mrst_pixel", pixel_a, 1'b0);
    chk("mrst_valid", valid_a, 1'b0);
    chk("mrst_line", line_a, 1'b0);
    chk("mrst_frame", frame_a, 1'b0);
    reset = 1'b0;
    addressM = 15'h0005;
    #1;
    chk("mrst_ram_kept", inM_a, 16'h1234);
    chk("b_ram_kept", inM_b, 16'h1234);
    chk("mrst_addr_err", addr_err_a, 1'b0);
    chk("b_mrst_addr_err", addr_err_b, 1'b0);
    chk("mrst_kbd_ready", kbd_ready_a, 1'b1);
    chk("b_kbd_ready", kbd_ready_b, 1'b1);
    addressM = 15'h6000;
    #1;
    chk("mrst_kbd_clear", inM_a, 16'h0000);
    tick();
    chk("rearm_load", valid_a, 1'b0);
    tick();
    chk("rearm_frame", frame_a, 1'b1);
    chk("rearm_line", line_a, 1'b1);
    chk("rearm_valid", valid_a, 1'b1);
    chk("rearm_pixel", pixel_a, 1'b1);
    scan_en_a = 1'b0;

    // Tiny frame (64 pixels): wrap without gap, same-edge write, drop scan_en mid-frame
    scan_en_b = 1'b1;
    tick();
    chk("b_load_gap", valid_b, 1'b0);
    tick();
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("b_valid_%0d", k), valid_b, 1'b1);
      chk($sformatf("b_pixel_%0d", k), pixel_b, exp_px_b(k));
      chk($sformatf("b_line_%0d", k), line_b, (k % 32) == 0);
      chk($sformatf("b_frame_%0d", k), frame_b, (k % 64) == 0);
      if (k == 95) begin
        addressM = 15'h4002; outM = 16'h0F0F; writeM = 1'b1;
      end else begin
        writeM = 1'b0;
      end
      if (k == 200) scan_en_b = 1'b0;
      tick();
    end
    chk("b_idle_valid", valid_b, 1'b0);
    chk("b_idle_pixel", pixel_b, 1'b0);
    chk("b_idle_line", line_b, 1'b0);
    chk("b_idle_frame", frame_b, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("b_stay_idle_%0d", j), valid_b, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
